// File: rtl/add_sub_arbiter_pkg.sv
// add_sub_arbiter_pkg: shared FSM encodings and helpers for the add/sub arbiter
package add_sub_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/add_sub.sv
// add_sub: WIRE-bit adder/subtractor; in subtract mode cin is a borrow-in and cout a borrow-out
module add_sub #(
  parameter int WIRE = 8
) (
  input  logic [WIRE-1:0] a,
  input  logic [WIRE-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic [WIRE-1:0] s,
  output logic            cout
);
  logic [WIRE:0] ext_a, ext_b, ext_c;
  assign ext_a = {1'b0, a};
  assign ext_b = {1'b0, b};
  assign ext_c = {{WIRE{1'b0}}, cin};
  assign {cout, s} = sub ? ext_a - ext_b - ext_c : ext_a + ext_b + ext_c;
endmodule

// File: rtl/add_sub_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first valid index at or after ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  g,
  output logic            any
);
  logic [NREQ-1:0] rot;
  logic [IDW:0]    off, sum;
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> ptr);
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) off = (IDW+1)'(k);
    sum = off + {1'b0, ptr};
    g = IDW'(sum >= (IDW+1)'(NREQ) ? sum - (IDW+1)'(NREQ) : sum);
    any = |req_valid;
    grant = any ? NREQ'(1) << g : '0;
  end
endmodule

// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: round-robin sharing of one add_sub datapath among NREQ requesters
module add_sub_arbiter
  import add_sub_arbiter_pkg::*;
#(
  parameter int WIRE = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WIRE-1:0] req_a,
  input  logic [NREQ*WIRE-1:0] req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [WIRE-1:0]      resp_s,
  output logic                 resp_cout,
  output logic                 busy
);
  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, id, g;
  logic [NREQ-1:0] grant;
  logic            any;
  logic [WIRE-1:0] a_q, b_q, sum_s;
  logic            cin_q, sub_q, sum_c;
  logic [WIRE-1:0] a_arr [NREQ];
  logic [WIRE-1:0] b_arr [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIRE +: WIRE];
    assign b_arr[i] = req_b[i*WIRE +: WIRE];
  end
  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid(req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .g        (g),
    .any      (any)
  );
  add_sub #(.WIRE(WIRE)) u_add_sub (
    .a   (a_q),
    .b   (b_q),
    .cin (cin_q),
    .sub (sub_q),
    .s   (sum_s),
    .cout(sum_c)
  );
  // grants are suppressed while reset is held so nothing is accepted into a discarded slot
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = any ? EXEC : IDLE;
    if (state == EXEC) state_nx = DONE;
    if (state == DONE) state_nx = resp_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      id         <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      sub_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_s     <= '0;
      resp_cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        a_q   <= a_arr[g];
        b_q   <= b_arr[g];
        cin_q <= req_cin[g];
        sub_q <= req_sub[g];
        id    <= g;
      end
      if (state == EXEC) begin
        resp_s     <= sum_s;
        resp_cout  <= sum_c;
        resp_id    <= id;
        resp_valid <= 1'b1;
      end
      // the served requester drops to lowest priority
      if (state == DONE && resp_ready) begin
        resp_valid <= 1'b0;
        ptr        <= IDW'(wrap_inc(int'(id), NREQ));
      end
    end
  end
endmodule
